// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer for the 16-bit ALU: fetches one instruction, decodes
// operands from a 16x16 register file, drives the ALU, then writes back result and flags.
module alu_sequencer #(
  parameter int NREG = 16,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [7:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_c,
  input  logic [W-1:0] alu_y,
  input  logic [4:0]   alu_flags,
  output logic [4:0]   psr,
  output logic         done,
  output logic         illegal,
  input  logic [3:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  localparam logic [7:0] OP_LSHI  = 8'h80;
  localparam logic [7:0] OP_RSHI  = 8'h81;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_CMPI  = 8'hB0;
  localparam logic [7:0] OP_CMPUI = 8'hE0;

  state_e         state_q, state_d;
  logic [15:0]    instr_q;
  logic [W-1:0]   regs_q [NREG];
  logic [4:0]     psr_q;
  logic [7:0]     alu_op_q;
  logic [W-1:0]   alu_a_q, alu_b_q;
  logic           alu_c_q;
  logic           legal_q, cmp_q;
  logic [W-1:0]   y_q;
  logic [4:0]     flags_q;

  logic [3:0]     opcode, ext, rdest, rsrc;
  logic [7:0]     dec_op;
  logic [W-1:0]   dec_b;
  logic           dec_legal, dec_cmp;

  assign opcode = instr_q[15:12];
  assign rdest  = instr_q[11:8];
  assign ext    = instr_q[7:4];
  assign rsrc   = instr_q[3:0];

  // Decode works on the captured word; operands are sampled at the DECODE->EXEC edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    dec_op    = '0;
    dec_b     = '0;
    dec_legal = 1'b0;
    if (opcode == 4'b0000 || opcode == 4'b1000) begin
      dec_op = {opcode, ext};
      dec_b  = regs_q[rsrc];
      if (dec_op == OP_LSHI || dec_op == OP_RSHI)
        dec_b = {{(W-4){1'b0}}, rsrc};
      if (opcode == 4'b0000)
        dec_legal = ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hF};
      else
        dec_legal = ext inside {4'h0, 4'h1, 4'h4, 4'h5, 4'hC, 4'hD};
    end else begin
      dec_op = {opcode, 4'b0000};
      dec_b  = {{(W-8){1'b0}}, instr_q[7:0]};
      case (opcode)
        4'b0101, 4'b0111, 4'b1001, 4'b1011: begin
          dec_b     = {{(W-8){instr_q[7]}}, instr_q[7:0]};
          dec_legal = 1'b1;
        end
        4'b0110, 4'b1010, 4'b1110: dec_legal = 1'b1;
        default:                   dec_legal = 1'b0;
      endcase
    end
    dec_cmp = (dec_op == OP_CMP) || (dec_op == OP_CMPI) || (dec_op == OP_CMPUI);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        illegal = ~legal_q;
        state_d = WB;
      end
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      psr_q    <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_c_q  <= 1'b0;
      legal_q  <= 1'b0;
      cmp_q    <= 1'b0;
      y_q      <= '0;
      flags_q  <= '0;
      // NOTE: the register file is reset explicitly, so it maps to flops, not a RAM macro.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (state_q == IDLE && instr_valid) instr_q <= instr;
      if (state_q == DECODE) begin
        alu_op_q <= dec_op;
        alu_a_q  <= regs_q[rdest];
        alu_b_q  <= dec_b;
        alu_c_q  <= psr_q[4];
        legal_q  <= dec_legal;
        cmp_q    <= dec_cmp;
      end
      if (state_q == EXEC) begin
        y_q     <= alu_y;
        flags_q <= alu_flags;
      end
      if (state_q == WB && legal_q) begin
        psr_q <= flags_q;
        if (!cmp_q) regs_q[rdest] <= y_q;
      end
    end
  end

  assign alu_op   = alu_op_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_c    = alu_c_q;
  assign psr      = psr_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule
